// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a circular-buffer FIFO.
// Frames are start, DATA_WIDTH data bits LSB first, optional parity,
// STOP_BITS stop bits, then an optional idle gap. Parity mode and gap length
// are captured when a word is popped, so they cannot change mid-frame.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [1:0]                    parity_mode,
    input  logic [3:0]                    gap_bits,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   DEPTH_L    = FIFO_DEPTH[AW:0];
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  overflow_q, overflow_d;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [3:0]            gap_q, gap_d;
    logic                  tx_q, tx_d;

    logic                  push;
    logic                  pop;
    logic                  bit_end;
    logic [DATA_WIDTH-1:0] head;

    assign full     = (count_q == DEPTH_L);
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign overflow = overflow_q;
    assign tx       = tx_q;
    assign busy     = (state_q != S_IDLE);
    assign head     = mem_q[rd_ptr_q];
    assign push     = wr_en && !full;
    assign bit_end  = (baud_q == BAUD_LAST);

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a dropped write beats clear)
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        overflow_d = overflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Frame sequencer: next state, counters, shift register and registered tx value
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        gap_d     = gap_q;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = head;
                    par_en_d  = (parity_mode == 2'd1) || (parity_mode == 2'd2);
                    par_bit_d = (^head) ^ (parity_mode == 2'd2);
                    gap_d     = gap_bits;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (gap_q != 4'd0) ? S_GAP : S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (bit_cnt_q == gap_q - 4'd1) begin
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Baud counter restarts on every state entry and at every bit boundary
        if ((state_d != state_q) || bit_end || (state_q == S_IDLE)) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + BW'(1);
        end

        // tx reflects the state being entered so the line changes on the same edge
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_bit_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            gap_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (1 and 2 stop bits) share all inputs.
// A frame-level model expands each popped word into its expected per-cycle
// line waveform and tracks the FIFO as a plain array.
module tb_uart_tx_fifo;

    localparam int C  = 4;
    localparam int DW = 8;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [1:0]    parity_mode;
    logic [3:0]    gap_bits;
    logic          clr_overflow;

    logic          tx0, busy0, full0, empty0, overflow0;
    logic [2:0]    level0;
    logic          tx1, busy1, full1, empty1, overflow1;
    logic [2:0]    level1;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .parity_mode(parity_mode), .gap_bits(gap_bits), .clr_overflow(clr_overflow),
        .tx(tx0), .busy(busy0), .full(full0), .empty(empty0), .level(level0),
        .overflow(overflow0));

    uart_tx_fifo #(.CLKS_PER_BIT(C), .DATA_WIDTH(DW), .FIFO_DEPTH(D), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .parity_mode(parity_mode), .gap_bits(gap_bits), .clr_overflow(clr_overflow),
        .tx(tx1), .busy(busy1), .full(full1), .empty(empty1), .level(level1),
        .overflow(overflow1));

    // ---------------- behavioural model ----------------
    logic [DW-1:0] mq    [2][D];
    int            mcnt  [2];
    logic          mov   [2];
    logic          mline [2][128];
    int            mlen  [2];
    int            mpos  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mov[k]  = 1'b0;
            mlen[k] = 0;
            mpos[k] = 0;
        end
    endtask

    task automatic model_step(input int k);
        logic          was_busy;
        logic          was_full;
        logic [DW-1:0] w;
        logic [31:0]   fb;
        int            nb;
        was_busy = (mpos[k] < mlen[k]);
        was_full = (mcnt[k] == D);
        if (was_busy) mpos[k]++;
        if (wr_en && was_full) mov[k] = 1'b1;
        else if (clr_overflow) mov[k] = 1'b0;
        if (!was_busy && mcnt[k] > 0) begin
            w = mq[k][0];
            for (int i = 0; i < D - 1; i++) mq[k][i] = mq[k][i+1];
            mcnt[k]--;
            fb = '0;
            nb = 0;
            fb[nb] = 1'b0; nb++;
            for (int i = 0; i < DW; i++) begin fb[nb] = w[i]; nb++; end
            if (parity_mode == 2'd1) begin fb[nb] = ^w; nb++; end
            else if (parity_mode == 2'd2) begin fb[nb] = ~^w; nb++; end
            for (int i = 0; i < k + 1; i++) begin fb[nb] = 1'b1; nb++; end
            for (int i = 0; i < int'(gap_bits); i++) begin fb[nb] = 1'b1; nb++; end
            for (int i = 0; i < nb; i++)
                for (int r = 0; r < C; r++) mline[k][i*C + r] = fb[i];
            mlen[k] = nb * C;
            mpos[k] = 0;
        end
        if (wr_en && !was_full) begin
            mq[k][mcnt[k]] = wr_data;
            mcnt[k]++;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_one(input int k, input logic t, input logic b, input logic f,
                               input logic e, input logic [2:0] l, input logic o);
        logic eb;
        eb = (mpos[k] < mlen[k]);
        check($sformatf("tx%0d", k),       32'(t), 32'(eb ? mline[k][mpos[k]] : 1'b1));
        check($sformatf("busy%0d", k),     32'(b), 32'(eb));
        check($sformatf("full%0d", k),     32'(f), 32'(mcnt[k] == D));
        check($sformatf("empty%0d", k),    32'(e), 32'(mcnt[k] == 0));
        check($sformatf("level%0d", k),    32'(l), 32'(mcnt[k]));
        check($sformatf("overflow%0d", k), 32'(o), 32'(mov[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_one(0, tx0, busy0, full0, empty0, level0, overflow0);
            compare_one(1, tx1, busy1, full1, empty1, level1, overflow1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write(input logic [DW-1:0] d, input logic [1:0] pm, input logic [3:0] g);
        wr_data     = d;
        parity_mode = pm;
        gap_bits    = g;
        wr_en       = 1'b1;
        @(negedge clk);
        wr_en       = 1'b0;
    endtask

    task automatic capture_frame(input int sel, output logic [31:0] bits, output int len);
        int guard;
        int c;
        guard = 0;
        c = 0;
        bits = '0;
        while (!(sel != 0 ? busy1 : busy0) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("frame_start_wait", 32'(guard < 400), 32'd1);
        while ((sel != 0 ? busy1 : busy0) && c < 400) begin
            if (c % C == 1 && c / C < 32) bits[c / C] = (sel != 0) ? tx1 : tx0;
            c++;
            @(negedge clk);
        end
        len = c;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (!(!busy0 && !busy1 && empty0 && empty1) && g < 10000) begin
            @(negedge clk);
            g++;
        end
        check("idle_wait", 32'(g < 10000), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] b;
        int n;
        int idle;

        reset = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        parity_mode = 2'd0;
        gap_bits = 4'd0;
        clr_overflow = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx",       32'(tx0), 32'd1);
        check("rst_busy",     32'(busy0), 32'd0);
        check("rst_full",     32'(full0), 32'd0);
        check("rst_empty",    32'(empty0), 32'd1);
        check("rst_level",    32'(level0), 32'd0);
        check("rst_overflow", 32'(overflow0), 32'd0);

        reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Even parity, 0x01
        write(8'h01, 2'd1, 4'd0);
        capture_frame(0, b, n);
        check("even_bits", 32'(b[10:0]), 32'h602);
        check("even_len", 32'(n), 32'd44);
        wait_idle();

        // Odd parity, 0x03
        write(8'h03, 2'd2, 4'd0);
        capture_frame(0, b, n);
        check("odd_bits", 32'(b[10:0]), 32'h606);
        check("odd_len", 32'(n), 32'd44);
        wait_idle();

        // No parity, 0x03
        write(8'h03, 2'd0, 4'd0);
        capture_frame(0, b, n);
        check("none_bits", 32'(b[9:0]), 32'h206);
        check("none_len", 32'(n), 32'd40);
        wait_idle();

        // Burst of six writes: first is popped mid-burst, sixth is dropped
        parity_mode = 2'd0;
        gap_bits = 4'd0;
        for (int i = 1; i <= 6; i++) begin
            wr_data = 8'(i);
            wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("burst_full", 32'(full0), 32'd1);
        check("burst_level", 32'(level0), 32'd4);
        check("burst_overflow", 32'(overflow0), 32'd1);
        check("burst_overflow_stop2", 32'(overflow1), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check("clr_overflow", 32'(overflow0), 32'd0);
        idle = 0;
        while (busy0 && idle < 400) begin @(negedge clk); idle++; end
        for (int i = 2; i <= 5; i++) begin
            capture_frame(0, b, n);
            check($sformatf("burst_word%0d", i), 32'(b[8:1]), 32'(i));
            check($sformatf("burst_len%0d", i), 32'(n), 32'd40);
        end
        wait_idle();

        // Gap insertion: two words with a 3-bit gap
        write(8'h5A, 2'd0, 4'd3);
        write(8'hC3, 2'd0, 4'd3);
        capture_frame(0, b, n);
        check("gap_word1", 32'(b[8:1]), 32'h5A);
        check("gap_len1", 32'(n), 32'd52);
        idle = 0;
        while (!busy0 && idle < 400) begin idle++; @(negedge clk); end
        check("gap_idle_cycles", 32'(idle), 32'd1);
        capture_frame(0, b, n);
        check("gap_word2", 32'(b[8:1]), 32'hC3);
        check("gap_len2", 32'(n), 32'd52);
        wait_idle();

        // Two stop bits on the second instance
        write(8'hA5, 2'd0, 4'd0);
        capture_frame(1, b, n);
        check("stop2_bits", 32'(b[10:0]), 32'h74A);
        check("stop2_len", 32'(n), 32'd44);
        wait_idle();

        // Reset during the data field with a word still queued
        write(8'h33, 2'd0, 4'd0);
        write(8'h44, 2'd0, 4'd0);
        repeat (C + 10) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_tx", 32'(tx0), 32'd1);
        check("midrst_empty", 32'(empty0), 32'd1);
        check("midrst_level", 32'(level0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_tx_stop2", 32'(tx1), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        write(8'h0F, 2'd0, 4'd0);
        capture_frame(0, b, n);
        check("postrst_bits", 32'(b[9:0]), 32'h21E);
        check("postrst_len", 32'(n), 32'd40);
        wait_idle();

        // Randomized traffic, every cycle checked against the model
        for (int cyc = 0; cyc < 800; cyc++) begin
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_data      = 8'($urandom);
            parity_mode  = 2'($urandom_range(0, 3));
            gap_bits     = 4'($urandom_range(0, 3));
            clr_overflow = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        clr_overflow = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, runtime-selectable parity (none/even/odd), 1 or 2 stop bits, and a programmable inter-frame idle gap. It is the synthesizable counterpart of the serial stimulus used to feed the processor's UART receiver. It sits on the peripheral side of the single-cycle RISC-V system and also serves as a reusable frame source in system benches. Words are queued by a write strobe and serialized LSB-first on `tx`.

## Interface
- `CLKS_PER_BIT`, 5208, clock cycles per serial bit; minimum 2.
- `DATA_WIDTH`, 8, data bits per frame; range 5–9.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, at least 2.
- `STOP_BITS`, 1, stop bits per frame; 1 or 2.
- `clk` in 1: single clock; all logic rises on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push `wr_data` into the FIFO this cycle.
- `wr_data` in DATA_WIDTH: word to queue.
- `parity_mode` in 2: 0 none, 1 even, 2 odd, 3 treated as none; sampled at frame start.
- `gap_bits` in 4: idle bit periods inserted after each frame's stop bits; sampled at frame start.
- `clr_overflow` in 1: clears `overflow`.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `full` out 1: FIFO holds FIFO_DEPTH entries.
- `empty` out 1: FIFO holds 0 entries.
- `level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky flag; set when a write is dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0. Reset clears FIFO pointers, the baud counter, the bit counter and the FSM (to IDLE).
- FIFO: circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo depth, plus a separate occupancy counter.
  - A write while `full` is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
  - A write and a pop in the same cycle (not full) leave `level` unchanged.
- `clr_overflow` clears `overflow`. If `clr_overflow` and a dropped write occur in the same cycle, set wins.
- FSM states: IDLE → START → DATA → PARITY → STOP → GAP → IDLE.
  - **IDLE:** `tx`=1. If `!empty`, pop the head word into the shift register, latch `parity_mode` and `gap_bits`, and go to START.
  - **START:** `tx`=0 for one bit period.
  - **DATA:** shift out DATA_WIDTH bits, LSB first, one bit period each.
  - **PARITY:** entered only when the latched mode is 1 or 2; otherwise DATA goes straight to STOP.
    - Even: the bit is the XOR of the data bits.
    - Odd: the bit is the inverted XOR.
  - **STOP:** `tx`=1 for STOP_BITS bit periods.
  - **GAP:** `tx`=1 for the latched `gap_bits` bit periods. It is skipped when `gap_bits`=0.
  - Exit: after STOP/GAP, return to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and restarts on every state entry.
  - A bit ends when the count reaches CLKS_PER_BIT-1.
  - Bit and stop/gap counters advance only at that point.
- `tx` is a registered output with no combinational path from inputs.

## Timing
- A write accepted at edge N makes `empty`=0 after edge N.
- The IDLE pop occurs at edge N+1, and `tx` falls after edge N+1.
- Write-to-start-bit latency: 1 cycle from FIFO non-empty.
- Frame length in cycles: CLKS_PER_BIT × (1 + DATA_WIDTH + P + STOP_BITS + gap), where P = 1 if parity is enabled, else 0.
- Back-to-back frames with `gap_bits`=0 and the FIFO non-empty: the next start bit follows the last stop bit after exactly 1 idle cycle (the IDLE pop cycle).
- `level` decrements on the pop edge.
- Changing `parity_mode` or `gap_bits` mid-frame has no effect until the next pop.
- Reset asserted mid-frame forces `tx`=1 immediately and discards the queued data.

## Test plan
Unless stated otherwise, tests use CLKS_PER_BIT=4, DATA_WIDTH=8, FIFO_DEPTH=4 and STOP_BITS=1.
- **Even parity, single word:** write 0x01 with `parity_mode`=1 and `gap_bits`=0.
  - `tx` = 0,1,0,0,0,0,0,0,0,1(parity),1(stop).
  - Each bit lasts 4 cycles; the frame is 44 cycles; `busy` stays high for 44 cycles.
- **Odd vs none:** write 0x03 with `parity_mode`=2, then with `parity_mode`=0.
  - Odd gives a parity bit of 1 and a 44-cycle frame.
  - None gives a 40-cycle frame with no parity slot.
- **Burst, overflow and clear:** write 0x01..0x06 on consecutive cycles while `tx` is idle.
  - The first pop happens during the burst, so the writes of 0x01–0x05 are accepted and `full` asserts.
  - The write of 0x06 is dropped and `overflow` goes to 1.
  - Output order is 0x01..0x05.
  - `clr_overflow` then clears `overflow`.
- **Gap insertion:** queue two words with `gap_bits`=3.
  - The second start bit falls 12+1 cycles after the first frame's stop bit ends.
- **Stop bits:** rebuild with STOP_BITS=2 and send 0xA5 with no parity.
  - The stop field is high for 8 cycles; total frame is 44 cycles.
- **Reset mid-frame:** assert `reset` low during the DATA state.
  - `tx`=1, `empty`=1 and `level`=0 immediately.
  - After release, a write of 0x0F transmits cleanly.
